// File: rtl/updown_pkg.sv
// Shared mode encodings for the parametrised up/down counter.
// Imported by the counter top and its next-state logic.
package updown_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

endpackage

// File: rtl/ud_next_val.sv
// Combinational next-state logic for one enabled counter step.
// Produces the next count, direction and terminal-count flag for the current mode.
module ud_next_val
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2 ** WIDTH - 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             up_down_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             next_dir_o,
  output logic             next_tc_o
);

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MaxMinus = MaxVal - One;

  logic             eff_up;
  logic             at_term;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] stepped;

  // Bounce follows its own direction register; the other modes follow up_down.
  always_comb begin
    eff_up   = (mode_i == MODE_BOUNCE) ? dir_i : up_down_i;
    term_val = eff_up ? MaxVal : '0;
    at_term  = (count_i == term_val);
    stepped  = eff_up ? (count_i + One) : (count_i - One);
  end

  always_comb begin
    next_count_o = count_i;
    next_dir_o   = dir_i;
    next_tc_o    = 1'b0;
    unique case (mode_i)
      MODE_WRAP: begin
        next_count_o = at_term ? (eff_up ? '0 : MaxVal) : stepped;
        next_dir_o   = up_down_i;
        next_tc_o    = at_term;
      end
      MODE_SAT: begin
        next_count_o = at_term ? count_i : stepped;
        next_dir_o   = up_down_i;
        next_tc_o    = at_term;
      end
      MODE_BOUNCE: begin
        if (at_term) begin
          next_count_o = eff_up ? MaxMinus : One;
          next_dir_o   = ~eff_up;
        end else begin
          next_count_o = stepped;
        end
        next_tc_o = at_term;
      end
      MODE_RSVD: begin
        next_count_o = count_i;
        next_dir_o   = dir_i;
        next_tc_o    = 1'b0;
      end
      default: begin
        next_count_o = count_i;
        next_dir_o   = dir_i;
        next_tc_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable and wrap/saturate/bounce overflow modes.
// Holds the state registers and applies reset > load > enable > hold priority.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2 ** WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_tc;
  logic [WIDTH-1:0] load_clamped;

  // A full-range modulus needs no clamp; skipping it avoids a constant compare.
  if (MAX_VAL == 2 ** WIDTH - 1) begin : g_no_clamp
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;
  end

  ud_next_val #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL)
  ) u_next (
    .count_i     (count_q),
    .dir_i       (dir_q),
    .up_down_i   (up_down),
    .mode_i      (mode),
    .next_count_o(step_count),
    .next_dir_o  (step_dir),
    .next_tc_o   (step_tc)
  );

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
      dir_d   = up_down;
    end else if (en) begin
      count_d = step_count;
      dir_d   = step_dir;
      tc_d    = step_tc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counters (MAX_VAL 255, 9, 3) share stimulus and are
// compared every edge against an arithmetic reference model plus directed expectations.
`timescale 1ns / 1ps
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] mode = 2'b00;

  logic [7:0] cnt[3];
  logic       dir_w[3];
  logic       tc_w[3];

  int vectors = 0;
  int miscompares = 0;

  int m_count[3];
  bit m_dir[3];
  bit m_tc[3];
  int mx[3] = '{255, 9, 3};

  int exp_b_cnt[7] = '{1, 2, 3, 2, 1, 0, 1};
  bit exp_b_tc[7] = '{0, 0, 0, 1, 0, 0, 1};
  bit exp_b_dir[7] = '{1, 1, 1, 0, 0, 0, 1};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(8), .MAX_VAL(255)) u_dut_255 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .mode(mode), .count(cnt[0]), .dir(dir_w[0]), .tc(tc_w[0])
  );
  updown_counter_param #(.WIDTH(8), .MAX_VAL(9)) u_dut_9 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .mode(mode), .count(cnt[1]), .dir(dir_w[1]), .tc(tc_w[1])
  );
  updown_counter_param #(.WIDTH(8), .MAX_VAL(3)) u_dut_3 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .mode(mode), .count(cnt[2]), .dir(dir_w[2]), .tc(tc_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bounce is modelled as a phase around a triangle of period 2*max.
  function automatic void model_step(int i);
    int c, per, p;
    bit up;
    c = m_count[i];
    if (!rst) begin
      m_count[i] = 0; m_dir[i] = 1; m_tc[i] = 0;
    end else if (load) begin
      m_count[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
      m_dir[i] = up_down; m_tc[i] = 0;
    end else if (!en || mode == 2'b11) begin
      m_tc[i] = 0;
    end else begin
      up = (mode == 2'b10) ? m_dir[i] : up_down;
      m_tc[i] = (c == (up ? mx[i] : 0));
      if (mode == 2'b00) begin
        m_count[i] = up ? (c + 1) % (mx[i] + 1) : (c + mx[i]) % (mx[i] + 1);
        m_dir[i] = up_down;
      end else if (mode == 2'b01) begin
        m_count[i] = up ? ((c + 1 > mx[i]) ? mx[i] : c + 1) : ((c == 0) ? 0 : c - 1);
        m_dir[i] = up_down;
      end else begin
        per = 2 * mx[i];
        p = up ? c : per - c;
        p = (p + 1) % per;
        m_count[i] = (p <= mx[i]) ? p : per - p;
        m_dir[i] = (p >= 1 && p <= mx[i]);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_count[%0d]", i), 32'(cnt[i]), 32'(m_count[i]));
      chk($sformatf("model_dir[%0d]", i), 32'(dir_w[i]), 32'(m_dir[i]));
      chk($sformatf("model_tc[%0d]", i), 32'(tc_w[i]), 32'(m_tc[i]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and release
    rst = 0; mode = 2'b00; up_down = 1; en = 1;
    step(); step();
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_dir", 32'(dir_w[0]), 1);
    chk("rst_tc", 32'(tc_w[0]), 0);
    rst = 1;
    repeat (5) step();
    chk("release_count", 32'(cnt[0]), 5);

    // Wrap on MAX_VAL=9
    load = 1; load_val = 8; up_down = 1;
    step();
    load = 0;
    step(); chk("wrap_9", 32'(cnt[1]), 9); chk("wrap_9_tc", 32'(tc_w[1]), 0);
    step(); chk("wrap_0", 32'(cnt[1]), 0); chk("wrap_0_tc", 32'(tc_w[1]), 1);
    step(); chk("wrap_1", 32'(cnt[1]), 1); chk("wrap_1_tc", 32'(tc_w[1]), 0);
    load = 1; load_val = 0; up_down = 0;
    step();
    load = 0;
    step(); chk("wrap_down", 32'(cnt[1]), 9); chk("wrap_down_tc", 32'(tc_w[1]), 1);
    chk("wrap_down_dir", 32'(dir_w[1]), 0);

    // Saturate on MAX_VAL=255
    mode = 2'b01; load = 1; load_val = 253; up_down = 1;
    step();
    load = 0;
    step(); chk("sat_254", 32'(cnt[0]), 254);
    step(); chk("sat_255", 32'(cnt[0]), 255); chk("sat_255_tc", 32'(tc_w[0]), 0);
    step(); chk("sat_pin1", 32'(cnt[0]), 255); chk("sat_pin1_tc", 32'(tc_w[0]), 1);
    step(); chk("sat_pin2", 32'(cnt[0]), 255); chk("sat_pin2_tc", 32'(tc_w[0]), 1);
    up_down = 0;
    step(); chk("sat_down", 32'(cnt[0]), 254); chk("sat_down_tc", 32'(tc_w[0]), 0);

    // Bounce on MAX_VAL=3; up_down toggles freely and must be ignored
    mode = 2'b10; load = 1; load_val = 0; up_down = 1;
    step();
    load = 0;
    for (int k = 0; k < 7; k++) begin
      up_down = 1'($urandom);
      step();
      chk($sformatf("bounce_cnt%0d", k), 32'(cnt[2]), 32'(exp_b_cnt[k]));
      chk($sformatf("bounce_tc%0d", k), 32'(tc_w[2]), 32'(exp_b_tc[k]));
      chk($sformatf("bounce_dir%0d", k), 32'(dir_w[2]), 32'(exp_b_dir[k]));
    end

    // Load clamp, then reset beating load
    mode = 2'b00; load = 1; load_val = 200; en = 1; up_down = 1;
    step(); chk("clamp_9", 32'(cnt[1]), 9); chk("clamp_tc", 32'(tc_w[1]), 0);
    chk("noclamp_200", 32'(cnt[0]), 200);
    rst = 0;
    step(); chk("rst_over_load9", 32'(cnt[1]), 0); chk("rst_over_load255", 32'(cnt[0]), 0);

    // Enable low, then reserved mode
    rst = 1; load = 0; mode = 2'b00; up_down = 1; en = 1;
    step(); step();
    en = 0;
    repeat (3) begin
      step();
      chk("hold_count", 32'(cnt[0]), 2); chk("hold_dir", 32'(dir_w[0]), 1);
      chk("hold_tc", 32'(tc_w[0]), 0);
    end
    mode = 2'b11; en = 1; up_down = 0;
    repeat (3) begin
      step();
      chk("rsvd_count", 32'(cnt[1]), 2); chk("rsvd_dir", 32'(dir_w[1]), 1);
      chk("rsvd_tc", 32'(tc_w[1]), 0);
    end

    // Randomised traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 49) != 0);
      load = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 9) != 0);
      up_down = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      load_val = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
